// File: rtl/boid_pkg.sv
// Shared types and constants for the boid frame sequencer and the datapath.
package boid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLreq,
    StLoad,
    StIter,
    StWb,
    StDone
  } seq_state_t;

  localparam int unsigned N_BOIDS_DEF  = 32;
  localparam logic [6:0]  WB_EN_ACTIVE = 7'b0000001;

  // fix15: signed 27-bit fixed point with 15 fractional bits, as used by xcel_dp
  typedef logic signed [26:0] fix15_t;

  localparam fix15_t FIX15_ONE         = 27'sd32768;
  localparam fix15_t FIX15_TURNFACTOR  = 27'sd6554;   // 0.2
  localparam fix15_t FIX15_VISUAL_RNG  = 27'sd1310720; // 40
  localparam fix15_t FIX15_PROTECT_RNG = 27'sd262144;  // 8
  localparam fix15_t FIX15_CENTERING   = 27'sd16;      // ~0.0005
  localparam fix15_t FIX15_AVOID       = 27'sd1638;    // 0.05
  localparam fix15_t FIX15_MATCHING    = 27'sd1638;    // 0.05
  localparam fix15_t FIX15_MAXSPEED    = 27'sd196608;  // 6
  localparam fix15_t FIX15_MINSPEED    = 27'sd98304;   // 3

endpackage

// File: rtl/boid_frame_seq_if.sv
// Control/address bundle between the frame sequencer and its host + M10K/datapath.
interface boid_frame_seq_if #(
  parameter int unsigned ADDR_W = 5
);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              r_en_tot;
  logic              r_en_itr;
  logic [6:0]        wb_en;
  logic [ADDR_W-1:0] boid_idx;

  // Sequencer side
  modport master (
    input  start,
    output busy, done, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
    output r_en_tot, r_en_itr, wb_en, boid_idx
  );

  // Host / memory / datapath side
  modport slave (
    output start,
    input  busy, done, rd_addr, rd_bank, wr_en, wr_addr, wr_bank,
    input  r_en_tot, r_en_itr, wb_en, boid_idx
  );

endinterface

// File: rtl/boid_idx_ctr.sv
// Saturating index counter with synchronous clear, enable and an at-max flag.
module boid_idx_ctr #(
  parameter int unsigned Width  = 5,
  parameter int unsigned MaxVal = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             at_max
);

  logic [Width-1:0] count_q, count_d;

  assign at_max = (count_q == Width'(MaxVal));
  assign count  = count_q;

  // Next count: clear wins; increment stops at MaxVal so it never wraps by overflow
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !at_max) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/boid_frame_seq.sv
// Per-frame sequencer: for each boid i, load self, stream all neighbours, write back.
// Two M10K banks ping-pong so neighbour reads always see the previous frame.
module boid_frame_seq
  import boid_pkg::*;
#(
  parameter int unsigned N_BOIDS = N_BOIDS_DEF,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  boid_frame_seq_if.master bus
);

  if (N_BOIDS < 2 || N_BOIDS > 64 || ADDR_W != $clog2(N_BOIDS)) begin : g_param_check
    $error("boid_frame_seq: N_BOIDS must be 2..64 and ADDR_W must be clog2(N_BOIDS)");
  end

  seq_state_t        state_q, state_d;
  logic              bank_q;
  logic [ADDR_W-1:0] i_cnt, j_cnt;
  logic              i_max, j_max;
  logic              i_clr, i_en, j_clr, j_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en, r_en_tot, r_en_itr, done;
  logic [6:0]        wb_en;

  boid_idx_ctr #(
    .Width  (ADDR_W),
    .MaxVal (N_BOIDS - 1)
  ) u_i_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (i_clr),
    .en     (i_en),
    .count  (i_cnt),
    .at_max (i_max)
  );

  boid_idx_ctr #(
    .Width  (ADDR_W),
    .MaxVal (N_BOIDS - 1)
  ) u_j_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (j_clr),
    .en     (j_en),
    .count  (j_cnt),
    .at_max (j_max)
  );

  // Next-state, counter control and Moore strobes; every strobe defaults low
  always_comb begin
    state_d  = state_q;
    i_clr    = 1'b0;
    i_en     = 1'b0;
    j_clr    = 1'b0;
    j_en     = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    r_en_tot = 1'b0;
    r_en_itr = 1'b0;
    wb_en    = '0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          i_clr   = 1'b1;
          state_d = StLreq;
        end
      end
      StLreq: begin
        rd_addr = i_cnt;
        state_d = StLoad;
      end
      StLoad: begin
        // self data on the bus now; prefetch neighbour 0
        r_en_tot = 1'b1;
        j_clr    = 1'b1;
        state_d  = StIter;
      end
      StIter: begin
        r_en_itr = (j_cnt != i_cnt);
        if (j_max) begin
          rd_addr = j_cnt;
          state_d = StWb;
        end else begin
          rd_addr = j_cnt + ADDR_W'(1);
          j_en    = 1'b1;
        end
      end
      StWb: begin
        wb_en = WB_EN_ACTIVE;
        wr_en = 1'b1;
        if (i_max) begin
          state_d = StDone;
        end else begin
          i_en    = 1'b1;
          state_d = StLreq;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Bank flips as DONE is left, so the new source is visible the cycle after done
  always_ff @(posedge clk) begin
    if (!reset)                 bank_q <= 1'b0;
    else if (state_q == StDone) bank_q <= ~bank_q;
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done;
  assign bus.rd_addr  = rd_addr;
  assign bus.rd_bank  = bank_q;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = i_cnt;
  assign bus.wr_bank  = ~bank_q;
  assign bus.r_en_tot = r_en_tot;
  assign bus.r_en_itr = r_en_itr;
  assign bus.wb_en    = wb_en;
  assign bus.boid_idx = i_cnt;

endmodule

// File: tb/tb_boid_frame_seq.sv
// Directed bench for boid_frame_seq: an N=4 instance and an N=32 instance share clk/reset.
// Expected writebacks are queued when a frame is started and popped on each wr_en.
module tb_boid_frame_seq;

  typedef struct packed {
    logic [4:0] addr;
    logic       bank;
  } wr_exp_t;

  logic clk;
  logic reset;

  boid_frame_seq_if #(.ADDR_W(2)) bus4 ();
  boid_frame_seq_if #(.ADDR_W(5)) bus32 ();

  boid_frame_seq #(
    .N_BOIDS (4),
    .ADDR_W  (2)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  boid_frame_seq #(
    .N_BOIDS (32),
    .ADDR_W  (5)
  ) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wr_exp_t q4[$];
  wr_exp_t q32[$];
  int wr4 = 0, tot4 = 0, itr4 = 0;
  int wr32 = 0, tot32 = 0, itr32 = 0;
  wr_exp_t e4, e32;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic bank);
    for (int k = 0; k < 4; k++) q4.push_back('{addr: 5'(k), bank: bank});
  endtask

  task automatic push32(input logic bank);
    for (int k = 0; k < 32; k++) q32.push_back('{addr: 5'(k), bank: bank});
  endtask

  // Monitor / scoreboard for the N=4 instance
  always @(negedge clk) begin
    if (bus4.r_en_tot) tot4++;
    if (bus4.r_en_itr) itr4++;
    if (bus4.wr_en || bus4.r_en_tot || bus4.r_en_itr)
      check("excl4", 32'(bus4.wr_en) + 32'(bus4.r_en_tot) + 32'(bus4.r_en_itr), 1);
    if (bus4.wr_en) begin
      wr4++;
      check("wr4_expected", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check("wr4_addr", 32'(bus4.wr_addr), 32'(e4.addr));
        check("wr4_bank", 32'(bus4.wr_bank), 32'(e4.bank));
        check("wr4_wb_en", 32'(bus4.wb_en), 1);
      end
    end
  end

  // Monitor / scoreboard for the N=32 instance
  always @(negedge clk) begin
    if (bus32.r_en_tot) tot32++;
    if (bus32.r_en_itr) itr32++;
    if (bus32.wr_en || bus32.r_en_tot || bus32.r_en_itr)
      check("excl32", 32'(bus32.wr_en) + 32'(bus32.r_en_tot) + 32'(bus32.r_en_itr), 1);
    if (bus32.wr_en) begin
      wr32++;
      check("wr32_expected", 32'(q32.size() != 0), 1);
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        check("wr32_addr", 32'(bus32.wr_addr), 32'(e32.addr));
        check("wr32_bank", 32'(bus32.wr_bank), 32'(e32.bank));
      end
    end
  end

  initial begin
    int cycles;
    int snap_wr, snap_tot, snap_itr;
    logic busy_seen;
    logic found;
    int addr_log[$];
    int itr_log[$];
    int exp_addr[6];
    int exp_itr[4];
    exp_addr = '{2, 0, 1, 2, 3, 3};
    exp_itr  = '{1, 1, 0, 1};

    // Reset and idle
    reset       = 1'b0;
    bus4.start  = 1'b0;
    bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus4.busy), 0);
    check("rst_done", 32'(bus4.done), 0);
    check("rst_strobes", {bus4.wr_en, bus4.r_en_tot, bus4.r_en_itr}, 0);
    check("rst_wb_en", 32'(bus4.wb_en), 0);
    check("rst_rd_addr", 32'(bus4.rd_addr), 0);
    check("rst_rd_bank", 32'(bus4.rd_bank), 0);
    check("rst_rd_bank32", 32'(bus32.rd_bank), 0);
    snap_wr   = wr4 + wr32;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus4.busy || bus32.busy) busy_seen = 1'b1;
    end
    #1;
    check("idle_busy", 32'(busy_seen), 0);
    check("idle_wr", wr4 + wr32 - snap_wr, 0);

    // N=4 frame 1: latency, strobe counts, self-skip and read-address trace for i=2
    push4(1'b1);
    snap_wr  = wr4;
    snap_tot = tot4;
    snap_itr = itr4;
    bus4.start = 1'b1;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      bus4.start = 1'b0;
      cycles++;
      if (bus4.busy && bus4.boid_idx == 2 && !bus4.wr_en && !bus4.done) begin
        addr_log.push_back(int'(bus4.rd_addr));
        itr_log.push_back(int'(bus4.r_en_itr));
      end
      if (bus4.done || cycles >= 200) break;
    end
    check("f1_done_latency", cycles, 29);
    check("f1_rd_bank", 32'(bus4.rd_bank), 0);
    #1;
    check("f1_wr_count", wr4 - snap_wr, 4);
    check("f1_tot_count", tot4 - snap_tot, 4);
    check("f1_itr_count", itr4 - snap_itr, 12);
    check("f1_sb_empty", q4.size(), 0);
    check("i2_trace_len", addr_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < addr_log.size()) check($sformatf("i2_rd_addr[%0d]", k), addr_log[k], exp_addr[k]);
    end
    for (int k = 0; k < 4; k++) begin
      if (k + 2 < itr_log.size()) check($sformatf("i2_itr[%0d]", k), itr_log[k+2], exp_itr[k]);
    end

    // N=4 frame 2 back to back: banks swapped
    @(negedge clk);
    check("f2_bank_toggled", 32'(bus4.rd_bank), 1);
    check("f2_idle_busy", 32'(bus4.busy), 0);
    push4(1'b0);
    bus4.start = 1'b1;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      bus4.start = 1'b0;
      cycles++;
      if (bus4.done || cycles >= 200) break;
    end
    check("f2_done_latency", cycles, 29);
    check("f2_rd_bank", 32'(bus4.rd_bank), 1);
    @(negedge clk);
    check("f2_bank_back", 32'(bus4.rd_bank), 0);
    check("f2_busy_drop", 32'(bus4.busy), 0);
    #1;
    check("f2_sb_empty", q4.size(), 0);

    // N=32: repeated starts mid-frame and a start coincident with done are ignored
    push32(1'b1);
    snap_wr = wr32;
    bus32.start = 1'b1;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      bus32.start = (cycles == 5 || cycles == 100 || cycles == 500);
      if (bus32.done || cycles >= 3000) begin
        bus32.start = 1'b1;
        break;
      end
    end
    check("n32_done_latency", cycles, 1121);
    @(negedge clk);
    bus32.start = 1'b0;
    check("n32_start_on_done_busy", 32'(bus32.busy), 0);
    check("n32_rd_bank", 32'(bus32.rd_bank), 1);
    repeat (2) @(negedge clk);
    check("n32_still_idle", 32'(bus32.busy), 0);
    #1;
    check("n32_wr_count", wr32 - snap_wr, 32);
    check("n32_sb_empty", q32.size(), 0);

    // N=32: reset during ITER of i=5 aborts before its writeback
    push32(1'b0);
    @(negedge clk);
    bus32.start = 1'b1;
    cycles = 0;
    found  = 1'b0;
    while (1) begin
      @(negedge clk);
      bus32.start = 1'b0;
      cycles++;
      if (bus32.boid_idx == 5 && bus32.r_en_itr) begin
        found = 1'b1;
        break;
      end
      if (cycles >= 3000) break;
    end
    check("abort_reached_i5", 32'(found), 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus32.busy), 0);
    check("abort_strobes", {bus32.wr_en, bus32.r_en_tot, bus32.r_en_itr}, 0);
    check("abort_rd_bank", 32'(bus32.rd_bank), 0);
    check("abort_idx", 32'(bus32.boid_idx), 0);
    reset = 1'b1;
    #1;
    check("abort_pending", q32.size(), 27);
    if (q32.size() != 0) check("abort_no_wr5", 32'(q32[0].addr), 5);
    q32.delete();

    // Fresh frame after abort writes 0..31 into bank 1
    push32(1'b1);
    snap_wr = wr32;
    @(negedge clk);
    bus32.start = 1'b1;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      bus32.start = 1'b0;
      cycles++;
      if (bus32.done || cycles >= 3000) break;
    end
    check("fresh_done_latency", cycles, 1121);
    #1;
    check("fresh_wr_count", wr32 - snap_wr, 32);
    check("fresh_sb_empty", q32.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boid_frame_seq.md
Name: boid_frame_seq

Overview:
- Per-frame sequencer directly upstream of the boid accelerator datapath (xcel_dp).
- Walks every boid i through four phases: load self, stream all N neighbours from M10K, write back, advance.
- Drives the datapath controls r_en_tot, r_en_itr and wb_en, plus the M10K read/write addresses.
- Ping-pongs two memory banks so neighbour reads always see the previous frame's state.

Parameters:
- N_BOIDS, 32, boids per frame; must be ≥2 and ≤64, to match the 6-bit neighbour counter downstream.
- ADDR_W, 5, address width; must equal clog2(N_BOIDS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; 0 at a clk edge resets the block.
- start  in  1  single-cycle pulse that begins a frame; ignored unless in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when a frame completes.
- rd_addr  out  ADDR_W  M10K read address; data is valid exactly one cycle later.
- rd_bank  out  1  bank being read, i.e. the current frame's source.
- wr_en  out  1  M10K write strobe for the datapath x/y/vx/vy outputs.
- wr_addr  out  ADDR_W  write address, always equal to i.
- wr_bank  out  1  write bank, always ~rd_bank.
- r_en_tot  out  1  datapath self-load and accumulator clear.
- r_en_itr  out  1  datapath neighbour-accumulate enable.
- wb_en  out  7  writeback gate; bit0 is used, bits 6:1 are tied to 0.
- boid_idx  out  ADDR_W  current self index i, for debug and VGA.

Behaviour:
- Reset (reset==0): state IDLE, i=0, j=0, bank=0.
  - Outputs: busy, done, wr_en, r_en_tot, r_en_itr = 0; wb_en=0; rd_addr=0; rd_bank=0.
  - Reset mid-frame aborts immediately. No write is issued in the reset cycle.
- States are IDLE, LREQ, LOAD, ITER, WB, DONE.
- IDLE: waits for start; on start goes to LREQ, sets i=0, busy=1.
- LREQ: rd_addr=i. Next state LOAD.
- LOAD: boid i data is on the bus.
  - r_en_tot=1, rd_addr=0, j=0. Next state ITER.
- ITER: data for neighbour j is on the bus.
  - r_en_itr=(j!=i); the self slot is skipped.
  - rd_addr=j+1 while j<N_BOIDS-1, else rd_addr holds.
  - If j==N_BOIDS-1, go to WB; otherwise j++.
- WB: wb_en=7'b0000001, wr_en=1, wr_addr=i, wr_bank=~bank.
  - If i==N_BOIDS-1, go to DONE; otherwise i++ and go to LREQ.
- DONE: done=1 for one cycle, bank toggles, busy drops next cycle, return to IDLE.
- Strobe exclusivity: at most one of r_en_tot, r_en_itr, wr_en is high in any cycle. All strobes are 0 outside their states.
- Latency: N_BOIDS+3 cycles per boid. A frame takes N_BOIDS*(N_BOIDS+3)+1 cycles from start acceptance to done; 1121 at N=32.
- Counters: i and j wrap only through explicit compare, never by overflow.
- A start arriving in the same cycle as done is ignored. Start is accepted only from IDLE.
- rd_bank is constant for the whole frame; the toggle is visible on the cycle done is high+1.

Decomposition:
- Package boid_pkg holds:
  - the state enum typedef seq_state_t;
  - localparams N_BOIDS_DEF=32 and WB_EN_ACTIVE=7'b0000001;
  - the fix15 constants shared with the datapath.
- Sub-module boid_idx_ctr: a parameterised counter with clear, enable and an at_max flag. It is instantiated twice, once for i and once for j.
- The FSM and bank register stay in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → all outputs 0 and rd_bank=0; no start for 20 cycles → busy stays 0 and wr_en never rises.
- Single frame, N=4: pulse start → done after exactly 4*7+1=29 cycles.
  - Exactly 4 wr_en pulses, with wr_addr 0,1,2,3 and wr_bank=1.
  - r_en_tot pulses exactly 4 times.
  - r_en_itr totals 12 cycles.
- Self-skip, N=4: during boid i=2 ITER → r_en_itr pattern is 1,1,0,1. Read-address sequence from LREQ onward is 2,0,1,2,3,3.
- Bank ping-pong: two back-to-back frames → frame 1 has rd_bank=0/wr_bank=1; frame 2 has rd_bank=1/wr_bank=0; rd_bank=0 again after the second done.
- Start while busy, N=32: repeat start pulses mid-frame → no restart; done still at cycle 1121. A start coincident with done is ignored.
- Reset mid-frame: assert reset=0 during the ITER of i=5 → next cycle IDLE, all strobes 0, bank=0, no write to address 5. A fresh start then writes addresses 0..31.
